// File: rtl/onehot_encoder32to5_pkg.sv
// Shared cache-side types: way count, encoded hit result and skid-buffer state.
package onehot_encoder32to5_pkg;

  localparam int N_WAYS    = 32;
  localparam int WAY_IDX_W = 5;

  typedef struct packed {
    logic [WAY_IDX_W-1:0] idx;
    logic                 hit;
    logic                 multi;
  } enc_result_t;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/onehot_encoder32to5_lsb_priority_enc32.sv
// Combinational LSB-priority encoder with zero-hot and multi-hot detection.
module lsb_priority_enc32
  import onehot_encoder32to5_pkg::*;
#(
  parameter int N_IN  = N_WAYS,
  parameter int W_IDX = WAY_IDX_W
) (
  input  logic [N_IN-1:0]  vec,
  output logic [W_IDX-1:0] idx,
  output logic             hit,
  output logic             multi
);

  always_comb begin
    idx = '0;
    // Scan from the top down so the lowest set bit is the last one written.
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (vec[i]) idx = W_IDX'(i);
    end
    hit   = |vec;
    multi = |(vec & (vec - N_IN'(1)));
  end

endmodule

// File: rtl/onehot_encoder32to5.sv
// Registered one-hot to binary encoder behind a 2-entry skid buffer, with multi-hot error accounting.
module onehot_encoder32to5
  import onehot_encoder32to5_pkg::*;
#(
  parameter int N_IN  = N_WAYS,
  parameter int W_IDX = WAY_IDX_W,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W_IDX-1:0] out_idx,
  output logic             out_hit,
  output logic             out_multi,
  output logic [ERR_W-1:0] err_cnt,
  output logic             err_sticky,
  input  logic             clr_err
);

  logic [W_IDX-1:0] enc_idx;
  logic             enc_hit;
  logic             enc_multi;
  enc_result_t      enc_res;

  lsb_priority_enc32 #(
    .N_IN  (N_IN),
    .W_IDX (W_IDX)
  ) u_enc (
    .vec   (in_vec),
    .idx   (enc_idx),
    .hit   (enc_hit),
    .multi (enc_multi)
  );

  assign enc_res = '{idx: enc_idx, hit: enc_hit, multi: enc_multi};

  skid_state_t      state_reg, state_next;
  enc_result_t      head_reg, tail_reg;
  logic             in_ready_reg;
  logic [ERR_W-1:0] err_cnt_reg;
  logic             err_sticky_reg;
  logic             accept, pop;

  assign accept    = in_valid & in_ready_reg;
  assign out_valid = (state_reg != SKID_EMPTY);
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      SKID_EMPTY: if (accept) state_next = SKID_ONE;
      SKID_ONE: begin
        if (accept && !pop)      state_next = SKID_FULL;
        else if (pop && !accept) state_next = SKID_EMPTY;
      end
      SKID_FULL:  if (pop) state_next = SKID_ONE;
      default:    state_next = SKID_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= SKID_EMPTY;
      head_reg     <= '0;
      tail_reg     <= '0;
      in_ready_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= (state_next != SKID_FULL);
      // The head slot always drives the outputs; the tail only holds the overflow entry.
      case (state_reg)
        SKID_EMPTY: if (accept) head_reg <= enc_res;
        SKID_ONE: begin
          if (accept && pop) head_reg <= enc_res;
          else if (accept)   tail_reg <= enc_res;
        end
        SKID_FULL:  if (pop) head_reg <= tail_reg;
        default: ;
      endcase
    end
  end

  // Clear takes priority over a simultaneous multi-hot accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_reg    <= '0;
      err_sticky_reg <= 1'b0;
    end else if (clr_err) begin
      err_cnt_reg    <= '0;
      err_sticky_reg <= 1'b0;
    end else if (accept && enc_multi) begin
      err_sticky_reg <= 1'b1;
      if (err_cnt_reg != '1) err_cnt_reg <= err_cnt_reg + ERR_W'(1);
    end
  end

  assign in_ready   = in_ready_reg;
  assign out_idx    = head_reg.idx;
  assign out_hit    = head_reg.hit;
  assign out_multi  = head_reg.multi;
  assign err_cnt    = err_cnt_reg;
  assign err_sticky = err_sticky_reg;

endmodule

// File: tb/tb_onehot_encoder32to5.sv
// Directed-vector bench for onehot_encoder32to5: encoding, skid backpressure, error saturation, async reset.
module tb_onehot_encoder32to5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_vec;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_idx;
  logic        out_hit;
  logic        out_multi;
  logic [7:0]  err_cnt;
  logic        err_sticky;
  logic        clr_err;

  int total = 0;
  int bad   = 0;

  onehot_encoder32to5 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_vec     (in_vec),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .out_hit    (out_hit),
    .out_multi  (out_multi),
    .err_cnt    (err_cnt),
    .err_sticky (err_sticky),
    .clr_err    (clr_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [4:0] idx, input logic hit, input logic multi);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".idx"},   32'(out_idx),   32'(idx));
    check({tag, ".hit"},   32'(out_hit),   32'(hit));
    check({tag, ".multi"}, 32'(out_multi), 32'(multi));
    $display("txn %s: idx=%0d hit=%0d multi=%0d err_cnt=%0d", tag, out_idx, out_hit, out_multi, err_cnt);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b0;
    clr_err   = 1'b0;
    #12;
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.in_ready",  32'(in_ready),  32'd1);
    check("rst.out_idx",   32'(out_idx),   32'd0);
    check("rst.out_hit",   32'(out_hit),   32'd0);
    check("rst.out_multi", 32'(out_multi), 32'd0);
    check("rst.err_cnt",   32'(err_cnt),   32'd0);
    check("rst.err_sticky",32'(err_sticky),32'd0);
    rst_n = 1'b1;
    tick();

    // Basic encoding with the consumer always ready.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_vec    = 32'h0000_0001;
    tick();
    check_out("bit0", 5'd0, 1'b1, 1'b0);
    in_vec = 32'h8000_0000;
    tick();
    check_out("bit31", 5'd31, 1'b1, 1'b0);
    in_vec = 32'h0000_0000;
    tick();
    check_out("zero", 5'd0, 1'b0, 1'b0);
    check("zero.err_cnt", 32'(err_cnt), 32'd0);
    in_vec = 32'h0000_0014;
    tick();
    check_out("multi14", 5'd2, 1'b1, 1'b1);
    check("multi14.err_cnt",    32'(err_cnt),    32'd1);
    check("multi14.err_sticky", 32'(err_sticky), 32'd1);
    clr_err = 1'b1;
    in_vec  = 32'h0000_0018;
    tick();
    check_out("clr18", 5'd3, 1'b1, 1'b1);
    check("clr18.err_cnt",    32'(err_cnt),    32'd0);
    check("clr18.err_sticky", 32'(err_sticky), 32'd0);
    clr_err  = 1'b0;
    in_valid = 1'b0;
    tick();
    check("drain.out_valid", 32'(out_valid), 32'd0);
    check("drain.in_ready",  32'(in_ready),  32'd1);

    // Backpressure: two entries fill the buffer, the third waits at the input.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_vec    = 32'h0000_0008;
    tick();
    check_out("bp.hold1", 5'd3, 1'b1, 1'b0);
    check("bp.ready1", 32'(in_ready), 32'd1);
    in_vec = 32'h0000_0080;
    tick();
    check_out("bp.hold2", 5'd3, 1'b1, 1'b0);
    check("bp.ready2", 32'(in_ready), 32'd0);
    in_vec = 32'h0000_0200;
    tick();
    check_out("bp.hold3", 5'd3, 1'b1, 1'b0);
    check("bp.ready3", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    check_out("bp.out7", 5'd7, 1'b1, 1'b0);
    check("bp.ready4", 32'(in_ready), 32'd1);
    tick();
    check_out("bp.out9", 5'd9, 1'b1, 1'b0);
    in_valid = 1'b0;
    tick();
    check("bp.empty", 32'(out_valid), 32'd0);

    // Error counter saturation.
    in_valid = 1'b1;
    in_vec   = 32'hFFFF_FFFF;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 254) check("sat.254", 32'(err_cnt), 32'd254);
      if (i == 255) check("sat.255", 32'(err_cnt), 32'd255);
    end
    check("sat.300", 32'(err_cnt), 32'd255);
    check("sat.sticky", 32'(err_sticky), 32'd1);
    check_out("sat.last", 5'd0, 1'b1, 1'b1);
    in_vec = 32'h8000_0004;
    tick();
    check_out("sat.hi_lo", 5'd2, 1'b1, 1'b1);
    check("sat.hold", 32'(err_cnt), 32'd255);

    // Asynchronous reset while FULL with a transfer pending.
    out_ready = 1'b0;
    in_vec    = 32'h0000_0006;
    tick();
    tick();
    check("ar.full_ready", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar.out_valid", 32'(out_valid), 32'd0);
    check("ar.in_ready",  32'(in_ready),  32'd1);
    check("ar.err_cnt",   32'(err_cnt),   32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ar.no_stale", 32'(out_valid), 32'd0);
    end
    check("ar.err_after", 32'(err_cnt), 32'd0);
    check("ar.sticky_after", 32'(err_sticky), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
